mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter sharing the single synchronous-read memory between
//  the cpu (port 0) and a second master such as a debug/loader unit (port 1).
//  Per transaction: latches one request, drives mem_we/mem_addr/mem_data, collects
//  mem_in after the memory's 1-cycle read latency, and returns a one-cycle ack.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of both master ports plus the memory-side bus of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_in;

  logic                  busy;
  logic                  owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_we, mem_addr, mem_data,
    input  mem_in,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_we, mem_addr, mem_data,
    output mem_in,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous-read memory.
// Each transaction takes IDLE -> ACCESS -> RESP, i.e. one access every 3 cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic                  last_reg;
  logic                  owner_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  logic                  req_any;
  logic                  winner;
  logic                  accept;

  assign req_any = bus.m0_req | bus.m1_req;
  // On contention the port that did not win last time goes first.
  assign winner  = bus.m1_req & (~bus.m0_req | ~last_reg);
  assign accept  = (state_reg == IDLE) & req_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (accept) begin
      last_reg  <= winner;
      owner_reg <= winner;
      we_reg    <= winner ? bus.m1_we    : bus.m0_we;
      addr_reg  <= winner ? bus.m1_addr  : bus.m0_addr;
      data_reg  <= winner ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // Read data is the memory output straight through, gated to the acked port.
  always_comb begin
    bus.mem_we   = (state_reg == ACCESS) & we_reg;
    bus.mem_addr = addr_reg;
    bus.mem_data = data_reg;
    bus.busy     = (state_reg != IDLE);
    bus.owner    = owner_reg;
    bus.m0_ack   = (state_reg == RESP) & ~owner_reg;
    bus.m1_ack   = (state_reg == RESP) & owner_reg;
    bus.m0_rdata = bus.m0_ack ? bus.mem_in : '0;
    bus.m1_rdata = bus.m1_ack ? bus.mem_in : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic from two masters,
// checked every cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  logic mem_init;

  mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        drv_req   [2];
  logic        drv_we    [2];
  logic [5:0]  drv_addr  [2];
  logic [15:0] drv_wdata [2];

  assign bus.m0_req   = drv_req[0];
  assign bus.m0_we    = drv_we[0];
  assign bus.m0_addr  = drv_addr[0];
  assign bus.m0_wdata = drv_wdata[0];
  assign bus.m1_req   = drv_req[1];
  assign bus.m1_we    = drv_we[1];
  assign bus.m1_addr  = drv_addr[1];
  assign bus.m1_wdata = drv_wdata[1];

  function automatic logic [15:0] init_word(input int i);
    return 16'hA500 ^ 16'(i * 257);
  endfunction

  // Synchronous-read memory the arbiter drives.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_data;
    end
    bus.mem_in <= mem[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;

  // Transaction-level model: edge count, edge of the last accept, in-flight request.
  logic [15:0] ref_mem [64];
  int          n;
  int          t_acc;
  int          cur_port;
  logic        cur_we;
  logic [5:0]  cur_addr;
  logic [15:0] cur_wdata;
  logic        last_win;
  logic        own;
  logic [5:0]  lat_addr;
  logic [15:0] lat_wdata;
  bit          pending  [2];
  bit          acc_flag [2];
  int          auto_cnt [2];
  logic [15:0] last_rdata [2];
  bit          scramble;
  int          acc_log [$];
  int          ack_t   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t_acc     = -100;
    cur_port  = 0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    last_win  = 1'b1;
    own       = 1'b0;
    lat_addr  = '0;
    lat_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      pending[p]  = 1'b0;
      acc_flag[p] = 1'b0;
      drv_req[p]  = 1'b0;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [5:0] a, input logic [15:0] wd);
    pending[p]   = 1'b1;
    acc_flag[p]  = 1'b0;
    drv_req[p]   = 1'b1;
    drv_we[p]    = we;
    drv_addr[p]  = a;
    drv_wdata[p] = wd;
    $display("t=%0t issue port=%0d we=%0d addr=%0d wdata=%h", $time, p, we, a, wd);
  endtask

  task automatic check_outputs();
    int d;
    d = n - t_acc;
    chk("busy",     bus.busy,     (d == 0) || (d == 1));
    chk("owner",    bus.owner,    own);
    chk("mem_we",   bus.mem_we,   (d == 0) && cur_we);
    chk("mem_addr", bus.mem_addr, lat_addr);
    chk("mem_data", bus.mem_data, lat_wdata);
    chk("m0_ack",   bus.m0_ack,   (d == 1) && (cur_port == 0));
    chk("m1_ack",   bus.m1_ack,   (d == 1) && (cur_port == 1));
    if (d == 1 && !cur_we) begin
      if (cur_port == 0) chk("m0_rdata", bus.m0_rdata, ref_mem[cur_addr]);
      else               chk("m1_rdata", bus.m1_rdata, ref_mem[cur_addr]);
    end
    if (!rst_n) begin
      chk("m0_rdata_rst", bus.m0_rdata, 16'h0);
      chk("m1_rdata_rst", bus.m1_rdata, 16'h0);
    end
  endtask

  task automatic step();
    int d;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      // A write lands in memory at the edge that closes its access cycle.
      if ((n - 1) - t_acc == 0 && cur_we) ref_mem[cur_addr] = cur_wdata;
      if (n - t_acc >= 3 && (drv_req[0] || drv_req[1])) begin
        int w;
        if (drv_req[0] && drv_req[1]) w = last_win ? 0 : 1;
        else                          w = drv_req[1] ? 1 : 0;
        t_acc       = n;
        cur_port    = w;
        cur_we      = drv_we[w];
        cur_addr    = drv_addr[w];
        cur_wdata   = drv_wdata[w];
        last_win    = (w == 1);
        own         = (w == 1);
        lat_addr    = drv_addr[w];
        lat_wdata   = drv_wdata[w];
        acc_flag[w] = 1'b1;
        acc_log.push_back(w);
      end
    end
    #1;
    check_outputs();
    d = n - t_acc;
    for (int p = 0; p < 2; p++) begin
      if (d == 1 && cur_port == p) begin
        pending[p]    = 1'b0;
        drv_req[p]    = 1'b0;
        ack_t.push_back(n);
        last_rdata[p] = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
        $display("t=%0t ack port=%0d we=%0d addr=%0d rdata=%h", $time, p, cur_we, cur_addr, last_rdata[p]);
        if (auto_cnt[p] > 0) begin
          auto_cnt[p]--;
          issue(p, 1'b0, 6'($urandom_range(0, 63)), 16'h0);
        end
      end else if (scramble && pending[p] && acc_flag[p]) begin
        drv_we[p]    = 1'($urandom_range(0, 1));
        drv_addr[p]  = 6'($urandom_range(0, 63));
        drv_wdata[p] = 16'($urandom);
      end
    end
  endtask

  task automatic wait_done(input int p, input int budget, input string tag);
    int k;
    k = 0;
    while (pending[p] && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, pending[p], 1'b0);
  endtask

  task automatic wait_accept(input int p, input int budget, input string tag);
    int k;
    k = 0;
    while (!acc_flag[p] && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_accept_timeout"}, acc_flag[p], 1'b1);
  endtask

  initial begin
    n = 0;
    scramble = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drv_we[p] = 1'b0; drv_addr[p] = '0; drv_wdata[p] = '0;
      auto_cnt[p] = 0; last_rdata[p] = '0;
    end
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst_n = 1'b0;
    mem_init = 1'b1;

    // Reset held for 3 cycles; outputs checked every cycle.
    step();
    mem_init = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // First request after reset is taken; then write 5.
    issue(0, 1'b1, 6'd5, 16'h1234);
    step();
    chk("t1_first_accept_busy", bus.busy, 1'b1);
    wait_done(0, 10, "t2_write5");

    issue(1, 1'b0, 6'd5, 16'h0);
    wait_done(1, 10, "t3_read5");
    chk("t3_rdata", last_rdata[1], 16'h1234);

    // Both ports hold requests for four transactions.
    acc_log.delete();
    ack_t.delete();
    auto_cnt[0] = 1;
    auto_cnt[1] = 1;
    issue(0, 1'b0, 6'd1, 16'h0);
    issue(1, 1'b0, 6'd2, 16'h0);
    begin
      int k;
      k = 0;
      while ((pending[0] || pending[1]) && k < 30) begin
        step();
        k++;
      end
    end
    chk("t4_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_owner_seq", acc_log[i], i % 2);
    end
    if (ack_t.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("t4_ack_gap", ack_t[i+1] - ack_t[i], 3);
    end

    // Address change after accept must not redirect the write.
    issue(0, 1'b1, 6'd63, 16'hBEEF);
    wait_accept(0, 10, "t5");
    drv_addr[0] = 6'd0;
    wait_done(0, 10, "t5_write63");
    issue(0, 1'b0, 6'd63, 16'h0);
    wait_done(0, 10, "t5_read63");
    chk("t5_rdata63", last_rdata[0], 16'hBEEF);
    issue(0, 1'b0, 6'd0, 16'h0);
    wait_done(0, 10, "t5_read0");
    chk("t5_rdata0", last_rdata[0], init_word(0));

    // Reset during the access cycle of a write to 9.
    issue(0, 1'b1, 6'd9, 16'h0F0F);
    wait_accept(0, 10, "t6");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    rst_n = 1'b1;
    issue(0, 1'b0, 6'd9, 16'h0);
    wait_done(0, 10, "t6_read9");
    chk("t6_rdata9", last_rdata[0], init_word(9));

    // Fresh contention just after reset: port 0 goes first.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    acc_log.delete();
    issue(0, 1'b0, 6'd3, 16'h0);
    issue(1, 1'b0, 6'd4, 16'h0);
    wait_done(0, 10, "t7_p0");
    wait_done(1, 10, "t7_p1");
    if (acc_log.size() >= 2) begin
      chk("t7_first", acc_log[0], 0);
      chk("t7_second", acc_log[1], 1);
    end else begin
      chk("t7_count", acc_log.size(), 2);
    end

    // Random traffic with post-accept field scrambling.
    scramble = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pending[p] && $urandom_range(0, 2) == 0) begin
          issue(p, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 7)),
                16'($urandom));
        end
      end
      step();
    end
    begin
      int k;
      k = 0;
      while ((pending[0] || pending[1]) && k < 20) begin
        step();
        k++;
      end
      chk("drain_timeout", {31'b0, pending[0] | pending[1]}, 32'd0);
    end
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
